brick_grid_controller: RTL and testbench

- Upstream stage of the white-brick bitmap renderer; owns the brick wall.
- Maps the VGA pixel position onto a GRID_ROWS x GRID_COLS matrix of 32x32 tiles and produces the per-tile offsetX/offsetY/InsideRectangle that the bitmap consumes.
- Records collision hits against individual bricks and removes those bricks frame-synchronously.
- Maintains a remaining-brick count for game logic.

---
 rtl/brick_grid_controller.sv | 177 +++++++++++++++++
 tb/tb_brick_grid_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_grid_controller.sv
// Brick wall owner: maps pixels onto the tile grid, latches
// collision hits and removes hit bricks with a per-frame row sweep.
module brick_grid_controller #(
    parameter int GRID_COLS = 16,
    parameter int GRID_ROWS = 8,
    parameter int TILE_BITS = 5,
    parameter int ORIGIN_X  = 64,
    parameter int ORIGIN_Y  = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        hitRequest,
    input  logic        restoreAll,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [7:0]  bricksLeft,
    output logic        wallCleared,
    output logic        busy
);

    localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam logic [7:0]  TOTAL  = 8'(GRID_ROWS * GRID_COLS);
    localparam logic [10:0] WALL_W = 11'(GRID_COLS << TILE_BITS);
    localparam logic [10:0] WALL_H = 11'(GRID_ROWS << TILE_BITS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RESTORE
    } state_t;

    state_t state_q;
    logic [ROW_W-1:0] sweep_q;
    logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_q;
    logic [GRID_ROWS-1:0][GRID_COLS-1:0] pend_q;
    logic [7:0] left_q;
    logic wc_q;
    logic busy_q;

    logic [10:0] offx_q, offy_q;
    logic inside_q;

    logic [ROW_W-1:0] p1_row_q, p2_row_q;
    logic [COL_W-1:0] p1_col_q, p2_col_q;
    logic p1_vld_q, p2_vld_q;

    logic [10:0] rel_x, rel_y;
    logic in_area;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic inside_d;
    logic [GRID_COLS-1:0] rm_mask;
    logic hit_fire;

    function automatic logic [7:0] popcnt(input logic [GRID_COLS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < GRID_COLS; i++) n = n + 8'(v[i]);
        return n;
    endfunction

    // Pixel-to-tile mapping; wrap-around makes left/above pixels huge.
    always_comb begin
        rel_x    = pixelX - 11'(ORIGIN_X);
        rel_y    = pixelY - 11'(ORIGIN_Y);
        in_area  = (rel_x < WALL_W) && (rel_y < WALL_H);
        col      = rel_x[TILE_BITS +: COL_W];
        row      = rel_y[TILE_BITS +: ROW_W];
        inside_d = in_area && grid_q[row][col];
        rm_mask  = grid_q[sweep_q] & pend_q[sweep_q];
        hit_fire = hitRequest && p2_vld_q && (state_q != RESTORE);
    end

    // Registered mapping outputs plus the 2-deep hit attribution pipe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offx_q   <= '0;
            offy_q   <= '0;
            inside_q <= 1'b0;
            p1_row_q <= '0;
            p1_col_q <= '0;
            p1_vld_q <= 1'b0;
            p2_row_q <= '0;
            p2_col_q <= '0;
            p2_vld_q <= 1'b0;
        end else begin
            offx_q   <= in_area ? 11'(rel_x[TILE_BITS-1:0]) : '0;
            offy_q   <= in_area ? 11'(rel_y[TILE_BITS-1:0]) : '0;
            inside_q <= inside_d;
            p1_row_q <= row;
            p1_col_q <= col;
            p1_vld_q <= inside_d;
            p2_row_q <= p1_row_q;
            p2_col_q <= p1_col_q;
            p2_vld_q <= p1_vld_q;
        end
    end

    // Sweep FSM owning grid, pending mask and brick count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            sweep_q <= '0;
            grid_q  <= '1;
            pend_q  <= '0;
            left_q  <= TOTAL;
            wc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wc_q <= (left_q == 8'd0);
            unique case (state_q)
                IDLE: begin
                    if (restoreAll) begin
                        state_q <= RESTORE;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end else if (startOfFrame && (pend_q != '0)) begin
                        state_q <= APPLY;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                APPLY: begin
                    if (restoreAll) begin
                        state_q <= RESTORE;
                        sweep_q <= '0;
                    end else begin
                        grid_q[sweep_q] <= grid_q[sweep_q] & ~pend_q[sweep_q];
                        pend_q[sweep_q] <= '0;
                        left_q <= left_q - popcnt(rm_mask);
                        if (sweep_q == LAST_ROW) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            sweep_q <= sweep_q + 1'b1;
                        end
                    end
                end
                RESTORE: begin
                    if (restoreAll) begin
                        sweep_q <= '0;
                    end else begin
                        grid_q[sweep_q] <= '1;
                        pend_q[sweep_q] <= '0;
                        if (sweep_q == LAST_ROW) begin
                            left_q  <= TOTAL;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            sweep_q <= sweep_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // A fresh hit beats the row clear issued in the same cycle.
            if (hit_fire) pend_q[p2_row_q][p2_col_q] <= 1'b1;
        end
    end

    assign offsetX         = offx_q;
    assign offsetY         = offy_q;
    assign InsideRectangle = inside_q;
    assign bricksLeft      = left_q;
    assign wallCleared     = wc_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_brick_grid_controller.sv
// Scoreboard bench for brick_grid_controller: stimulus queues
// cycle-tagged expectations, a negedge monitor pops and compares.
module tb_brick_grid_controller;

    localparam int ROWS = 8;
    localparam int K_OX = 0;
    localparam int K_OY = 1;
    localparam int K_INS = 2;
    localparam int K_LEFT = 3;
    localparam int K_WC = 4;
    localparam int K_BUSY = 5;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic resetN;
    logic [10:0] pixelX, pixelY;
    logic startOfFrame, hitRequest, restoreAll;
    logic [10:0] offsetX, offsetY;
    logic InsideRectangle;
    logic [7:0] bricksLeft;
    logic wallCleared, busy;

    exp_t sb[$];
    string nm[$];
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    brick_grid_controller dut (
        .clk(clk),
        .resetN(resetN),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .startOfFrame(startOfFrame),
        .hitRequest(hitRequest),
        .restoreAll(restoreAll),
        .offsetX(offsetX),
        .offsetY(offsetY),
        .InsideRectangle(InsideRectangle),
        .bricksLeft(bricksLeft),
        .wallCleared(wallCleared),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                n_total++;
                $display("FAIL %s: expectation expired at cycle %0d",
                         nm[i], cyc);
                sb.delete(i);
                nm.delete(i);
            end else if (sb[i].cyc == cyc) begin
                int act;
                case (sb[i].kind)
                    K_OX:    act = int'(offsetX);
                    K_OY:    act = int'(offsetY);
                    K_INS:   act = int'(InsideRectangle);
                    K_LEFT:  act = int'(bricksLeft);
                    K_WC:    act = int'(wallCleared);
                    default: act = int'(busy);
                endcase
                n_total++;
                if (act == sb[i].val) n_pass++;
                else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                              nm[i], act, sb[i].val, cyc);
                sb.delete(i);
                nm.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
    endtask

    task automatic expect_at(input int d, input int k, input int v,
                             input string n);
        exp_t e;
        e.cyc = cyc + d;
        e.kind = k;
        e.val = v;
        sb.push_back(e);
        nm.push_back(n);
    endtask

    // Sweep the pixel across tiles idx0..idx0+n-1 with hitRequest held.
    task automatic hit_tiles(input int idx0, input int n);
        pix(0, 0);
        tick();
        tick();
        hitRequest = 1'b1;
        for (int i = idx0; i < idx0 + n; i++) begin
            pix(64 + 32 * (i % 16) + 3, 32 + 32 * (i / 16) + 7);
            tick();
        end
        pix(0, 0);
        tick();
        tick();
        hitRequest = 1'b0;
        tick();
    endtask

    // Pulse startOfFrame and expect a full 8-row APPLY sweep.
    task automatic frame(input int left, input string tag);
        startOfFrame = 1'b1;
        expect_at(0, K_BUSY, 0, {tag, "_busy_pre"});
        for (int d = 1; d <= ROWS; d++)
            expect_at(d, K_BUSY, 1, {tag, "_busy"});
        expect_at(ROWS + 1, K_BUSY, 0, {tag, "_busy_post"});
        expect_at(ROWS + 1, K_LEFT, left, {tag, "_bricksLeft"});
        tick();
        startOfFrame = 1'b0;
        repeat (ROWS + 1) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        pix(0, 0);
        startOfFrame = 1'b0;
        hitRequest = 1'b0;
        restoreAll = 1'b0;
        tick();
        tick();
        expect_at(0, K_OX, 0, "rst_offsetX");
        expect_at(0, K_OY, 0, "rst_offsetY");
        expect_at(0, K_INS, 0, "rst_inside");
        expect_at(0, K_LEFT, 128, "rst_bricksLeft");
        expect_at(0, K_WC, 0, "rst_wallCleared");
        expect_at(0, K_BUSY, 0, "rst_busy");
        tick();
        resetN = 1'b1;
        tick();

        // Mapping corners and edges.
        pix(64, 32);
        expect_at(1, K_OX, 0, "origin_offsetX");
        expect_at(1, K_OY, 0, "origin_offsetY");
        expect_at(1, K_INS, 1, "origin_inside");
        expect_at(1, K_LEFT, 128, "origin_bricksLeft");
        tick();
        pix(63, 32);
        expect_at(1, K_INS, 0, "left_of_origin");
        expect_at(1, K_OX, 0, "left_of_origin_offsetX");
        tick();
        pix(575, 287);
        expect_at(1, K_INS, 1, "far_corner_inside");
        expect_at(1, K_OX, 31, "far_corner_offsetX");
        expect_at(1, K_OY, 31, "far_corner_offsetY");
        tick();
        pix(576, 100);
        expect_at(1, K_INS, 0, "right_edge_outside");
        tick();
        pix(100, 31);
        expect_at(1, K_INS, 0, "above_origin_outside");
        tick();

        // Single hit on row0/col1, removed at next frame.
        pix(100, 40);
        expect_at(1, K_INS, 1, "hit1_inside");
        expect_at(1, K_OX, 4, "hit1_offsetX");
        expect_at(1, K_OY, 8, "hit1_offsetY");
        tick();
        pix(0, 0);
        tick();
        hitRequest = 1'b1;
        tick();
        hitRequest = 1'b0;
        tick();
        frame(127, "frame1");
        pix(100, 40);
        expect_at(1, K_INS, 0, "removed_inside");
        expect_at(1, K_OX, 4, "removed_offsetX");
        expect_at(1, K_OY, 8, "removed_offsetY");
        tick();

        // Triple hit on row0/col0 plus one invalid hit.
        pix(64, 32);
        tick();
        tick();
        hitRequest = 1'b1;
        tick();
        pix(10, 10);
        tick();
        tick();
        tick();
        hitRequest = 1'b0;
        pix(0, 0);
        tick();
        frame(126, "frame2");

        // Clear the whole wall over two frames.
        hit_tiles(0, 64);
        frame(64, "frame3");
        hit_tiles(64, 64);
        expect_at(ROWS + 1, K_WC, 0, "clear_wc_not_yet");
        expect_at(ROWS + 2, K_WC, 1, "clear_wc_set");
        frame(0, "frame4");
        tick();

        // Restore the wall.
        restoreAll = 1'b1;
        expect_at(0, K_BUSY, 0, "restore_busy_pre");
        for (int d = 1; d <= ROWS; d++)
            expect_at(d, K_BUSY, 1, "restore_busy");
        expect_at(ROWS + 1, K_BUSY, 0, "restore_busy_post");
        expect_at(ROWS + 1, K_LEFT, 128, "restore_bricksLeft");
        expect_at(ROWS + 1, K_WC, 1, "restore_wc_lag");
        expect_at(ROWS + 2, K_WC, 0, "restore_wc_clear");
        tick();
        restoreAll = 1'b0;
        repeat (ROWS + 2) tick();
        for (int i = 0; i < 128; i++) begin
            pix(64 + 32 * (i % 16) + 17, 32 + 32 * (i / 16) + 9);
            expect_at(1, K_INS, 1, "restored_tile");
            tick();
        end

        // restoreAll in the 3rd APPLY cycle with 5 pending bricks.
        hit_tiles(0, 5);
        startOfFrame = 1'b1;
        for (int d = 1; d <= 3 + ROWS; d++)
            expect_at(d, K_BUSY, 1, "abort_busy");
        expect_at(4 + ROWS, K_BUSY, 0, "abort_busy_post");
        expect_at(2, K_LEFT, 123, "abort_partial_left");
        expect_at(4 + ROWS, K_LEFT, 128, "abort_final_left");
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
        restoreAll = 1'b1;
        tick();
        restoreAll = 1'b0;
        repeat (ROWS + 2) tick();
        startOfFrame = 1'b1;
        expect_at(1, K_BUSY, 0, "pending_empty_busy1");
        expect_at(2, K_BUSY, 0, "pending_empty_busy2");
        expect_at(2, K_LEFT, 128, "pending_empty_left");
        pix(64, 32);
        expect_at(1, K_INS, 1, "abort_tile0_present");
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < sb.size(); i++) begin
            n_total++;
            $display("FAIL %s: never checked", nm[i]);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
